uart_tx_fifo: RTL

- Buffering and handshake stage directly upstream of uart_tx.
- Accepts bytes from the interface/ALU side into a synchronous FIFO.
- Issues them one at a time to uart_tx with a single-cycle start pulse. Holds the data word stable and waits for the done tick before issuing the next byte.
- Decouples producers from the slow serial line and flags overflow.

---
 rtl/uart_tx_fifo_pkg.sv | 12 +
 rtl/fifo_sync.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 91 +++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the uart_tx_fifo slice: FSM state encoding and default widths.
package uart_tx_fifo_pkg;

    localparam int NB_STATE    = 2;
    localparam int NB_DATA_DEF = 8;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE      = 2'b01,
        ST_WAIT_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with a combinational head read. Writes to a full FIFO and
// reads from an empty FIFO are ignored.
module fifo_sync
    import uart_tx_fifo_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_rd,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [NB_ADDR:0]   o_count
);

    localparam int unsigned DEPTH = 2 ** NB_ADDR;
    localparam logic [NB_ADDR:0] FULL_CNT = {1'b1, {NB_ADDR{1'b0}}};

    logic [NB_DATA-1:0] mem_q [DEPTH];
    logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [NB_ADDR:0]   count_q, count_d;
    logic               wr_en, rd_en;

    always_comb begin
        o_full   = (count_q == FULL_CNT);
        o_empty  = (count_q == '0);
        o_count  = count_q;
        o_rdata  = mem_q[rd_ptr_q];
        wr_en    = i_wr && !o_full;
        rd_en    = i_rd && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally at NB_ADDR bits.
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !rd_en) count_d = count_q + 1'b1;
        else if (rd_en && !wr_en) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst && wr_en) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers bytes ahead of uart_tx and hands them over one at a time with a
// one-cycle start pulse, waiting for the done tick between bytes.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [NB_ADDR:0]   o_count,
    output logic               o_overflow,
    input  logic               i_clr_ovf,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy
);

    state_e             state_q, state_d;
    logic               tx_start_q, tx_start_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               ovf_q, ovf_d;
    logic               pop;
    logic [NB_DATA-1:0] fifo_rdata;
    logic               fifo_full, fifo_empty;

    fifo_sync #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_wr    (i_wr),
        .i_wdata (i_wdata),
        .i_rd    (pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (o_count)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:      state_d = fifo_empty ? ST_IDLE : ST_WAIT_DONE;
            ST_WAIT_DONE: state_d = i_tx_done ? ST_IDLE : ST_WAIT_DONE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_IDLE: pop = !fifo_empty;
            default: pop = 1'b0;
        endcase
        tx_start_d = pop;
        tx_data_d  = pop ? fifo_rdata : tx_data_q;
        // A dropped write outranks a simultaneous clear.
        if (i_wr && fifo_full) ovf_d = 1'b1;
        else if (i_clr_ovf)    ovf_d = 1'b0;
        else                   ovf_d = ovf_q;
    end

    assign o_full     = fifo_full;
    assign o_empty    = fifo_empty;
    assign o_overflow = ovf_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = !fifo_empty || (state_q == ST_WAIT_DONE);

endmodule
